ysyx_22040895_idreg: RTL

YSYX_22040895_IDREG -- requirements
Module: ysyx_22040895_idreg

---
 rtl/ysyx_22040895_idreg_if.sv | 32 +++
 rtl/ysyx_22040895_idreg.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22040895_idreg_if.sv
// Handshake bundle between IF, the ID pipeline register and the decode consumer.
// master = IF/consumer side (drives in_*, flush, out_ready), slave = the ID register.
interface ysyx_22040895_idreg_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic [63:0] in_pc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [6:0]  out_opcode;
  logic [4:0]  out_rd;
  logic [4:0]  out_rs1;
  logic [4:0]  out_rs2;
  logic [11:0] out_imm1;
  logic [19:0] out_imm2;
  logic        out_immsel;
  logic        out_illegal;

  modport master (
    output in_valid, in_inst, in_pc, flush, out_ready,
    input  in_ready, out_valid, out_pc, out_opcode, out_rd, out_rs1, out_rs2,
           out_imm1, out_imm2, out_immsel, out_illegal
  );

  modport slave (
    input  in_valid, in_inst, in_pc, flush, out_ready,
    output in_ready, out_valid, out_pc, out_opcode, out_rd, out_rs1, out_rs2,
           out_imm1, out_imm2, out_immsel, out_illegal
  );
endinterface

// File: rtl/ysyx_22040895_idreg.sv
// ID-stage pipeline register: valid/ready instruction buffer with field and immediate decode.
// Define YSYX_22040895_SKID_EN for a two-entry skid buffer whose in_ready comes from state only.

module ysyx_22040895_idreg_chk (
  input logic        clk,
  input logic        rst,
  input logic        flush,
  input logic        in_ready,
  input logic        out_valid,
  input logic        out_ready,
  input logic [63:0] out_pc,
  input logic [6:0]  out_opcode
);
  a_rst_blocks_input: assert property (@(posedge clk) rst |-> !in_ready);

  a_stall_holds_head: assert property (@(posedge clk) disable iff (rst)
    (out_valid && !out_ready && !flush) |=> (out_valid && $stable(out_pc) && $stable(out_opcode)));

  a_flush_empties: assert property (@(posedge clk) disable iff (rst) flush |=> !out_valid);
endmodule

module ysyx_22040895_idreg (
  input logic                  clk,
  input logic                  rst,
  ysyx_22040895_idreg_if.slave bus
);
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_REG32  = 7'b0111011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t      state_r;
  logic        out_valid_r;
  logic        in_ready_s;
  logic        push_s;
  logic        pop_s;
  logic [31:0] head_inst_s;
  logic [63:0] head_pc_s;
  logic [6:0]  opcode_s;
  logic [11:0] imm1_s;
  logic [19:0] imm2_s;
  logic        immsel_s;
  logic        illegal_s;

  // Flush kills both sides of the transfer in the same cycle.
  assign push_s = bus.in_valid && in_ready_s && !bus.flush;
  assign pop_s  = out_valid_r && bus.out_ready && !bus.flush;

`ifdef YSYX_22040895_SKID_EN
  logic [31:0] inst_mem_r [2];
  logic [63:0] pc_mem_r [2];
  logic        head_r;
  logic        wr_idx_s;

  assign in_ready_s = !rst && (state_r != ST_TWO);
  assign wr_idx_s   = (state_r == ST_ONE) ? ~head_r : head_r;

  // Two-entry circular storage; head advances on every pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_r <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        inst_mem_r[i] <= 32'd0;
        pc_mem_r[i]   <= 64'd0;
      end
    end else begin
      if (push_s) begin
        inst_mem_r[wr_idx_s] <= bus.in_inst;
        pc_mem_r[wr_idx_s]   <= bus.in_pc;
      end
      if (pop_s) begin
        head_r <= ~head_r;
      end
    end
  end

  assign head_inst_s = inst_mem_r[head_r];
  assign head_pc_s   = pc_mem_r[head_r];
`else
  logic [31:0] inst_r;
  logic [63:0] pc_r;

  // A pop in the same cycle frees the single slot, so in_ready passes out_ready through.
  assign in_ready_s = !rst && ((state_r == ST_EMPTY) || bus.out_ready);

  // Single-entry storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      inst_r <= 32'd0;
      pc_r   <= 64'd0;
    end else if (push_s) begin
      inst_r <= bus.in_inst;
      pc_r   <= bus.in_pc;
    end
  end

  assign head_inst_s = inst_r;
  assign head_pc_s   = pc_r;
`endif

  // Occupancy FSM; out_valid is registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_EMPTY;
      out_valid_r <= 1'b0;
    end else if (bus.flush) begin
      state_r     <= ST_EMPTY;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (push_s) begin
            state_r     <= ST_ONE;
            out_valid_r <= 1'b1;
          end
        end
        ST_ONE: begin
          if (push_s && !pop_s) begin
`ifdef YSYX_22040895_SKID_EN
            state_r <= ST_TWO;
`else
            state_r <= ST_ONE;
`endif
          end else if (!push_s && pop_s) begin
            state_r     <= ST_EMPTY;
            out_valid_r <= 1'b0;
          end
        end
        ST_TWO: begin
          if (pop_s) begin
            state_r <= ST_ONE;
          end
        end
        default: begin
          state_r     <= ST_EMPTY;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign opcode_s = head_inst_s[6:0];

  // Immediate extraction by format; everything reads zero while the buffer is empty.
  always_comb begin
    imm1_s    = 12'd0;
    imm2_s    = 20'd0;
    immsel_s  = 1'b0;
    illegal_s = 1'b0;
    if (out_valid_r) begin
      case (opcode_s)
        OP_IMM, OP_LOAD, OP_JALR, OP_IMM32, OP_SYSTEM: begin
          imm1_s   = head_inst_s[31:20];
          immsel_s = 1'b1;
        end
        OP_STORE: begin
          imm1_s   = {head_inst_s[31:25], head_inst_s[11:7]};
          immsel_s = 1'b1;
        end
        OP_BRANCH: begin
          imm1_s   = {head_inst_s[31], head_inst_s[7], head_inst_s[30:25], head_inst_s[11:8]};
          immsel_s = 1'b1;
        end
        OP_LUI, OP_AUIPC: begin
          imm2_s   = head_inst_s[31:12];
          immsel_s = 1'b0;
        end
        OP_JAL: begin
          imm2_s   = {head_inst_s[31], head_inst_s[19:12], head_inst_s[20], head_inst_s[30:21]};
          immsel_s = 1'b0;
        end
        OP_REG, OP_REG32: begin
          immsel_s = 1'b1;
        end
        default: begin
          illegal_s = 1'b1;
        end
      endcase
    end else begin
      imm1_s    = 12'd0;
      imm2_s    = 20'd0;
      immsel_s  = 1'b0;
      illegal_s = 1'b0;
    end
  end

  assign bus.in_ready    = in_ready_s;
  assign bus.out_valid   = out_valid_r;
  assign bus.out_pc      = out_valid_r ? head_pc_s : 64'd0;
  assign bus.out_opcode  = out_valid_r ? opcode_s : 7'd0;
  assign bus.out_rd      = out_valid_r ? head_inst_s[11:7] : 5'd0;
  assign bus.out_rs1     = out_valid_r ? head_inst_s[19:15] : 5'd0;
  assign bus.out_rs2     = out_valid_r ? head_inst_s[24:20] : 5'd0;
  assign bus.out_imm1    = imm1_s;
  assign bus.out_imm2    = imm2_s;
  assign bus.out_immsel  = immsel_s;
  assign bus.out_illegal = illegal_s;

  ysyx_22040895_idreg_chk u_chk (
    .clk        (clk),
    .rst        (rst),
    .flush      (bus.flush),
    .in_ready   (bus.in_ready),
    .out_valid  (bus.out_valid),
    .out_ready  (bus.out_ready),
    .out_pc     (bus.out_pc),
    .out_opcode (bus.out_opcode)
  );
endmodule
